// File: rtl/io_bank_arbiter.sv
// Shared 32-bit IO register bank behind the PCI BAR0 window. Port 0 (PCI) has fixed priority.
// Local ports share access round-robin, with a lock for read-modify-write and a lock-hold watchdog.
module io_bank_arbiter #(
    parameter int NREQ     = 4,
    parameter int AW       = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NREQ-1:0]     req_i,
    input  logic [NREQ-1:0]     lock_i,
    input  logic [NREQ-1:0]     we_i,
    input  logic [NREQ*AW-1:0]  addr_i,
    input  logic [NREQ*32-1:0]  wdata_i,
    output logic [NREQ-1:0]     gnt_o,
    output logic [NREQ-1:0]     ack_o,
    output logic [31:0]         rdata_o,
    output logic                lockErr_o,
    input  logic                errClr_i
);

    localparam int PW    = $clog2(NREQ);
    localparam int HW    = $clog2(MAX_HOLD + 1);
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d, ack_q, ack_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            lockErr_q, lockErr_d;
    logic [PW-1:0]   rrPtr_q, rrPtr_d;
    logic [HW-1:0]   holdCnt_q, holdCnt_d;
    logic [31:0]     bank_q [DEPTH];

    logic [PW-1:0]   gIdx, arbWin, candIdx;
    logic [NREQ-1:0] arbReq;
    logic            arbFound, lockHeld, keepLock, wdFire, bankWe;
    logic [AW-1:0]   accAddr;
    logic [31:0]     accWdata;
    int              candPos;

    always_comb begin
        gIdx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_q[k]) gIdx = PW'(k);
        end
    end

    assign accAddr  = addr_i[int'(gIdx)*AW +: AW];
    assign accWdata = wdata_i[int'(gIdx)*32 +: 32];
    assign lockHeld = lock_i[gIdx] & req_i[gIdx];
    assign keepLock = (state_q == DONE) && lockHeld && (holdCnt_q <  HW'(MAX_HOLD - 1));
    assign wdFire   = (state_q == DONE) && lockHeld && (holdCnt_q >= HW'(MAX_HOLD - 1));

    // A broken lock owner sits out the arbitration round in which it is evicted.
    always_comb begin
        arbReq   = req_i;
        arbFound = 1'b0;
        arbWin   = '0;
        candPos  = 0;
        candIdx  = '0;
        if (wdFire) arbReq[gIdx] = 1'b0;
        if (arbReq[0]) begin
            arbFound = 1'b1;
        end else begin
            for (int k = 0; k < NREQ - 1; k++) begin
                candPos = int'(rrPtr_q) + k;
                if (candPos > NREQ - 1) candPos = candPos - (NREQ - 1);
                candIdx = PW'(candPos);
                if (!arbFound && arbReq[candIdx]) begin
                    arbFound = 1'b1;
                    arbWin   = candIdx;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        rrPtr_d   = rrPtr_q;
        holdCnt_d = holdCnt_q;
        case (state_q)
            ACC: state_d = DONE;
            default: begin
                if (keepLock) begin
                    state_d   = ACC;
                    holdCnt_d = holdCnt_q + HW'(1);
                end else begin
                    holdCnt_d = '0;
                    state_d   = arbFound ? ACC : IDLE;
                    if (arbFound && arbWin != '0)
                        rrPtr_d = (arbWin == PW'(NREQ - 1)) ? PW'(1) : arbWin + PW'(1);
                end
            end
        endcase
    end

    always_comb begin
        gnt_d     = gnt_q;
        ack_d     = '0;
        rdata_d   = rdata_q;
        bankWe    = 1'b0;
        lockErr_d = lockErr_q;
        if (errClr_i) lockErr_d = 1'b0;
        if (wdFire)   lockErr_d = 1'b1;
        case (state_q)
            ACC: begin
                ack_d = gnt_q;
                if (we_i[gIdx]) bankWe  = 1'b1;
                else            rdata_d = bank_q[accAddr];
            end
            default: begin
                if (!keepLock) gnt_d = arbFound ? (NREQ'(1) << arbWin) : '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gnt_q     <= '0;
            ack_q     <= '0;
            rdata_q   <= '0;
            lockErr_q <= 1'b0;
            rrPtr_q   <= PW'(1);
            holdCnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) bank_q[i] <= '0;
        end else begin
            gnt_q     <= gnt_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
            lockErr_q <= lockErr_d;
            rrPtr_q   <= rrPtr_d;
            holdCnt_q <= holdCnt_d;
            if (bankWe) bank_q[accAddr] <= accWdata;
        end
    end

    assign gnt_o     = gnt_q;
    assign ack_o     = ack_q;
    assign rdata_o   = rdata_q;
    assign lockErr_o = lockErr_q;

endmodule

// File: tb/tb_io_bank_arbiter.sv
// Self-checking bench for io_bank_arbiter: directed scenarios plus random traffic,
// compared every cycle against a transaction-level model of the bank and arbiter.
module tb_io_bank_arbiter;

    localparam int NREQ     = 4;
    localparam int AW       = 3;
    localparam int MAX_HOLD = 4;
    localparam int DEPTH    = 1 << AW;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NREQ-1:0]     reqV, lockV, weV;
    logic [NREQ*AW-1:0]  addrV;
    logic [NREQ*32-1:0]  wdataV;
    logic                errClr;
    logic [NREQ-1:0]     gnt, ack;
    logic [31:0]         rdata;
    logic                lockErr;

    int nChecks = 0;
    int nPass   = 0;
    int tickCnt = 0;
    bit autoDrop [NREQ];
    int ackLog[$];
    int ackCyc[$];
    int rrOrder [6]   = '{1, 2, 3, 1, 2, 3};
    int prioOrder [3] = '{0, 2, 1};

    // Model: who holds the bank (-1 = nobody), whether the access runs now or is being acknowledged.
    int          mCur, mAck, mRr, mHold;
    bit          mRunning, mAcking, mErr, mRdValid;
    logic [31:0] mRdata;
    logic [31:0] mBank [DEPTH];

    io_bank_arbiter #(.NREQ(NREQ), .AW(AW), .MAX_HOLD(MAX_HOLD)) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .req_i    (reqV),
        .lock_i   (lockV),
        .we_i     (weV),
        .addr_i   (addrV),
        .wdata_i  (wdataV),
        .gnt_o    (gnt),
        .ack_o    (ack),
        .rdata_o  (rdata),
        .lockErr_o(lockErr),
        .errClr_i (errClr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, tickCnt);
    endtask

    task automatic modelReset();
        mCur = -1; mAck = -1; mRr = 1; mHold = 0;
        mRunning = 0; mAcking = 0; mErr = 0; mRdValid = 0; mRdata = '0;
        for (int i = 0; i < DEPTH; i++) mBank[i] = '0;
    endtask

    function automatic int pickWinner(input int excl);
        int c;
        if (reqV[0] && excl != 0) return 0;
        for (int k = 0; k < NREQ - 1; k++) begin
            c = (mRr - 1 + k) % (NREQ - 1) + 1;
            if (reqV[c] && c != excl) return c;
        end
        return -1;
    endfunction

    task automatic modelStep();
        int excl, w;
        logic [AW-1:0] a;
        if (errClr) mErr = 0;
        if (mRunning) begin
            a = addrV[mCur*AW +: AW];
            mRdValid = !weV[mCur];
            if (weV[mCur]) mBank[a] = wdataV[mCur*32 +: 32];
            else           mRdata   = mBank[a];
            mAck = mCur; mRunning = 0; mAcking = 1;
        end else begin
            excl = -1; mAck = -1; mRdValid = 0;
            if (mAcking && lockV[mCur] && reqV[mCur]) begin
                if (mHold < MAX_HOLD - 1) begin
                    mHold++; mRunning = 1; mAcking = 0;
                end else begin
                    mErr = 1; excl = mCur;
                end
            end
            if (!mRunning) begin
                mHold = 0; mAcking = 0;
                w = pickWinner(excl);
                mCur = w;
                mRunning = (w >= 0);
                if (w > 0) mRr = w % (NREQ - 1) + 1;
            end
        end
    endtask

    // One clock: advance the model on the rising edge, compare on the falling edge.
    task automatic tick();
        logic [NREQ-1:0] eg, ea;
        @(posedge clk);
        if (!rst_n) modelReset();
        else        modelStep();
        @(negedge clk);
        tickCnt++;
        eg = (mCur >= 0) ? (NREQ'(1) << mCur) : '0;
        ea = (mAck >= 0) ? (NREQ'(1) << mAck) : '0;
        checkOutput("gnt", 32'(gnt), 32'(eg));
        checkOutput("ack", 32'(ack), 32'(ea));
        checkOutput("lock_err", 32'(lockErr), 32'(mErr));
        if (mRdValid) checkOutput("rdata", rdata, mRdata);
        for (int p = 0; p < NREQ; p++) begin
            if (ack[p]) begin
                ackLog.push_back(p);
                ackCyc.push_back(tickCnt);
                if (autoDrop[p]) begin reqV[p] = 1'b0; lockV[p] = 1'b0; end
            end
        end
    endtask

    task automatic setOp(input int p, input bit we, input int addr, input logic [31:0] data, input bit lk);
        reqV[p]  = 1'b1;
        lockV[p] = lk;
        weV[p]   = we;
        addrV[p*AW +: AW]   = AW'(addr);
        wdataV[p*32 +: 32]  = data;
    endtask

    task automatic waitAcks(input int n, input int budget, input string name);
        int t = 0;
        while (ackLog.size() < n && t < budget) begin tick(); t++; end
        checkOutput(name, 32'(ackLog.size() >= n), 32'd1);
    endtask

    task automatic readPort(input int p, input int addr, input logic [31:0] exp);
        setOp(p, 1'b0, addr, '0, 1'b0);
        ackLog.delete();
        waitAcks(1, 10, "read_ack");
        checkOutput("read_data", rdata, exp);
    endtask

    task automatic applyStimulus();
        for (int p = 0; p < NREQ; p++) begin
            if (ack[p]) begin
                if ((lockV[p] && $urandom_range(0, 3) != 0) || $urandom_range(0, 7) == 0)
                    setOp(p, 1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), $urandom, lockV[p]);
                else begin
                    reqV[p] = 1'b0; lockV[p] = 1'b0;
                end
            end else if (!reqV[p]) begin
                if ($urandom_range(0, 3) == 0)
                    setOp(p, 1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), $urandom,
                          ($urandom_range(0, 3) == 0));
            end else if (gnt[p] && $urandom_range(0, 15) == 0) begin
                reqV[p] = 1'b0; lockV[p] = 1'b0;
            end
        end
        errClr = ($urandom_range(0, 15) == 0);
    endtask

    initial begin
        int n1;
        rst_n = 1'b0; reqV = '0; lockV = '0; weV = '0; addrV = '0; wdataV = '0; errClr = 1'b0;
        for (int p = 0; p < NREQ; p++) autoDrop[p] = 1;
        modelReset();
        repeat (3) tick();
        checkOutput("reset_gnt", 32'(gnt), 32'd0);
        checkOutput("reset_ack", 32'(ack), 32'd0);
        checkOutput("reset_rdata", rdata, 32'd0);
        checkOutput("reset_lock_err", 32'(lockErr), 32'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] round-robin among ports 1..3");
        for (int p = 1; p < NREQ; p++) begin
            autoDrop[p] = 0;
            setOp(p, 1'b0, p, '0, 1'b0);
        end
        ackLog.delete(); ackCyc.delete();
        waitAcks(6, 30, "rr_acks");
        reqV = '0;
        for (int p = 0; p < NREQ; p++) autoDrop[p] = 1;
        if (ackLog.size() >= 6) begin
            for (int i = 0; i < 6; i++) checkOutput("rr_order", 32'(ackLog[i]), 32'(rrOrder[i]));
            for (int i = 1; i < 6; i++) checkOutput("rr_spacing", 32'(ackCyc[i] - ackCyc[i-1]), 32'd2);
        end
        repeat (2) tick();

        $display("[TB] write then read on port 1");
        setOp(1, 1'b1, 5, 32'h12345678, 1'b0);
        tick();
        checkOutput("lat_gnt", 32'(gnt), 32'h2);
        checkOutput("lat_ack_early", 32'(ack), 32'h0);
        tick();
        checkOutput("lat_ack", 32'(ack), 32'h2);
        tick();
        for (int a = 0; a < DEPTH; a++) readPort(1, a, (a == 5) ? 32'h12345678 : 32'h0);
        tick();

        $display("[TB] port 0 priority");
        setOp(0, 1'b0, 5, '0, 1'b0);
        setOp(1, 1'b0, 0, '0, 1'b0);
        setOp(2, 1'b0, 5, '0, 1'b0);
        ackLog.delete();
        waitAcks(3, 20, "prio_acks");
        if (ackLog.size() >= 3)
            for (int i = 0; i < 3; i++) checkOutput("prio_order", 32'(ackLog[i]), 32'(prioOrder[i]));
        tick();

        $display("[TB] locked read-modify-write on port 3");
        autoDrop[3] = 0;
        setOp(3, 1'b0, 2, '0, 1'b1);
        tick();
        checkOutput("lock_gnt3", 32'(gnt), 32'h8);
        setOp(0, 1'b0, 2, '0, 1'b0);
        tick();
        checkOutput("lock_rd_ack", 32'(ack), 32'h8);
        checkOutput("lock_rd_data", rdata, 32'h0);
        setOp(3, 1'b1, 2, 32'hA5, 1'b1);
        tick();
        checkOutput("lock_hold_gnt", 32'(gnt), 32'h8);
        tick();
        checkOutput("lock_wr_ack", 32'(ack), 32'h8);
        reqV[3] = 1'b0; lockV[3] = 1'b0; autoDrop[3] = 1;
        tick();
        checkOutput("lock_p0_gnt", 32'(gnt), 32'h1);
        tick();
        checkOutput("lock_p0_ack", 32'(ack), 32'h1);
        checkOutput("lock_p0_rdata", rdata, 32'hA5);
        tick();

        $display("[TB] lock watchdog on port 1");
        autoDrop[1] = 0;
        setOp(1, 1'b0, 0, '0, 1'b1);
        setOp(2, 1'b0, 1, '0, 1'b0);
        ackLog.delete();
        waitAcks(5, 30, "wd_acks");
        reqV[1] = 1'b0; lockV[1] = 1'b0; autoDrop[1] = 1;
        if (ackLog.size() >= 5) begin
            n1 = 0;
            for (int i = 0; i < 5; i++) if (ackLog[i] == 1) n1++;
            checkOutput("wd_port1_acks", 32'(n1), 32'd4);
            checkOutput("wd_next_port", 32'(ackLog[4]), 32'd2);
        end
        checkOutput("wd_lock_err", 32'(lockErr), 32'd1);
        tick();
        errClr = 1'b1;
        tick();
        errClr = 1'b0;
        checkOutput("err_clr", 32'(lockErr), 32'd0);
        tick();

        $display("[TB] reset during a write access");
        setOp(1, 1'b1, 7, 32'hFFFFFFFF, 1'b0);
        tick();
        checkOutput("rst_acc_gnt", 32'(gnt), 32'h2);
        rst_n = 1'b0; reqV = '0; lockV = '0;
        modelReset();
        #1;
        checkOutput("rst_async_gnt", 32'(gnt), 32'h0);
        checkOutput("rst_async_ack", 32'(ack), 32'h0);
        tick();
        checkOutput("rst_no_ack", 32'(ack), 32'h0);
        rst_n = 1'b1;
        tick();
        readPort(1, 7, 32'h0);
        readPort(1, 5, 32'h0);
        tick();

        $display("[TB] random traffic");
        for (int p = 0; p < NREQ; p++) autoDrop[p] = 0;
        for (int i = 0; i < 600; i++) begin
            tick();
            applyStimulus();
        end
        reqV = '0; lockV = '0; errClr = 1'b0;
        repeat (4) tick();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
